// File: rtl/pipe_pkg.sv
// pipe_pkg
//   Shared constants for the inter-stage pipeline registers.
//   - state_e  : skid-buffer fill state; its encoding doubles as the occupancy count.
//   - PC_RESET : reset PC that callers put in the PC field of RESET_DATA.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    localparam logic [31:0] PC_RESET = 32'h8000_0000;

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot
//   One payload register with a load enable. Async active-low reset loads RESET_DATA.
//   clk    in  1       rising-edge clock
//   reset  in  1       async active-low reset
//   load   in  1       capture d this cycle
//   d      in  DATA_W  payload in
//   q      out DATA_W  held payload
module pipe_slot #(
    parameter int                 DATA_W     = 8,
    parameter logic [DATA_W-1:0]  RESET_DATA = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (load) data_d = d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) data_q <= RESET_DATA;
        else        data_q <= data_d;
    end

    assign q = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf
//   Generic inter-stage pipeline register with valid/ready handshake, synchronous flush and
//   an optional 2-entry skid buffer (SKID=1) so a downstream stall does not reach in_ready
//   combinationally.
//   clk        in   1       rising-edge clock
//   reset      in   1       async active-low reset
//   flush      in   1       sync kill of every held entry (wins over in/out activity)
//   in_valid   in   1       upstream payload valid
//   in_ready   out  1       stage accepts payload this cycle
//   in_data    in   DATA_W  upstream payload
//   out_valid  out  1       downstream payload valid
//   out_ready  in   1       downstream accepts this cycle
//   out_data   out  DATA_W  payload to next stage
//   occupancy  out  2       entries held
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int                 DATA_W     = 32*5+5,
    parameter logic [DATA_W-1:0]  RESET_DATA = '0,
    parameter bit                 SKID       = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    if (SKID) begin : g_skid
        state_e            state_q, state_d;
        logic              in_ready_q, in_ready_d;
        logic              in_fire, out_fire;
        logic              main_ld, skid_ld;
        logic [DATA_W-1:0] main_d, main_q, skid_q;

        assign in_fire  = in_valid & in_ready_q;
        assign out_fire = (state_q != ST_EMPTY) & out_ready;

        always_comb begin
            state_d = state_q;
            main_ld = 1'b0;
            skid_ld = 1'b0;
            main_d  = in_data;
            case (state_q)
                ST_EMPTY: if (in_fire) begin
                    state_d = ST_ONE;
                    main_ld = 1'b1;
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_ld = 1'b1;
                    end else if (in_fire) begin
                        state_d = ST_TWO;
                        skid_ld = 1'b1;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: if (out_fire) begin
                    // skid entry is older than anything upstream: promote it
                    state_d = ST_ONE;
                    main_ld = 1'b1;
                    main_d  = skid_q;
                end
                default: state_d = ST_EMPTY;
            endcase
            // data regs may still load on flush; their contents are don't-care once empty
            if (flush) state_d = ST_EMPTY;
            // registered ready: looks ahead at the next state instead of at out_ready
            in_ready_d = (state_d != ST_TWO);
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q    <= ST_EMPTY;
                in_ready_q <= 1'b1;
            end else begin
                state_q    <= state_d;
                in_ready_q <= in_ready_d;
            end
        end

        pipe_slot #(.DATA_W(DATA_W), .RESET_DATA(RESET_DATA)) u_main (
            .clk(clk), .reset(reset), .load(main_ld), .d(main_d), .q(main_q)
        );
        pipe_slot #(.DATA_W(DATA_W), .RESET_DATA(RESET_DATA)) u_skid (
            .clk(clk), .reset(reset), .load(skid_ld), .d(in_data), .q(skid_q)
        );

        assign in_ready  = in_ready_q;
        assign out_valid = (state_q != ST_EMPTY);
        assign out_data  = main_q;
        assign occupancy = state_q;
    end else begin : g_single
        logic valid_q, valid_d;
        logic in_fire;

        assign in_ready = out_ready | ~valid_q;
        assign in_fire  = in_valid & in_ready;

        always_comb begin
            valid_d = valid_q;
            if (in_fire)        valid_d = 1'b1;
            else if (out_ready) valid_d = 1'b0;
            if (flush)          valid_d = 1'b0;
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) valid_q <= 1'b0;
            else        valid_q <= valid_d;
        end

        pipe_slot #(.DATA_W(DATA_W), .RESET_DATA(RESET_DATA)) u_main (
            .clk(clk), .reset(reset), .load(in_fire), .d(in_data), .q(out_data)
        );

        assign out_valid = valid_q;
        assign occupancy = {1'b0, valid_q};
    end

endmodule
